cpu_sequencer: RTL

Multi-cycle instruction sequencer for the virtual CPU.
- Fetches a 16-bit instruction from instruction memory and latches it in an internal IR.
- Walks each instruction through DECODE/EXEC/MEM/WB states, asserting ALU, memory, register-write and PC-update strobes on the correct cycle.
- Sits between instruction memory, data memory, the ALU and the register file, and owns the PC.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/cpu_decode.sv | 40 ++++
 rtl/cpu_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared opcode, ALU-class and FSM-state definitions for the virtual CPU.
package cpu_pkg;

  localparam int unsigned OPC_W = 8;

  localparam logic [OPC_W-1:0] OP_AND    = 8'h00;
  localparam logic [OPC_W-1:0] OP_OR     = 8'h01;
  localparam logic [OPC_W-1:0] OP_ADD    = 8'h02;
  localparam logic [OPC_W-1:0] OP_SUB    = 8'h03;
  localparam logic [OPC_W-1:0] OP_LOAD   = 8'h04;
  localparam logic [OPC_W-1:0] OP_STORE  = 8'h05;
  localparam logic [OPC_W-1:0] OP_BRANCH = 8'h06;
  localparam logic [OPC_W-1:0] OP_HALT   = 8'hFF;

  localparam logic [1:0] ALU_NONE  = 2'd0;
  localparam logic [1:0] ALU_LOGIC = 2'd1;
  localparam logic [1:0] ALU_ARITH = 2'd2;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

endpackage

// File: rtl/cpu_decode.sv
// Combinational opcode-to-class decoder; exactly one class flag is high.
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [7:0] opcode,
  output logic       is_alu,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_halt,
  output logic       is_illegal,
  output logic [1:0] alu_op
);

  always_comb begin
    is_alu     = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_branch  = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    alu_op     = ALU_NONE;
    case (opcode)
      OP_AND, OP_OR: begin
        is_alu = 1'b1;
        alu_op = ALU_LOGIC;
      end
      OP_ADD, OP_SUB: begin
        is_alu = 1'b1;
        alu_op = ALU_ARITH;
      end
      OP_LOAD:   is_load   = 1'b1;
      OP_STORE:  is_store  = 1'b1;
      OP_BRANCH: is_branch = 1'b1;
      OP_HALT:   is_halt   = 1'b1;
      default:   is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning PC, IR and the retired counter.
// Strobes are registered from the next state, so each one is high exactly while its state is active.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  output logic               dmem_rd,
  output logic               dmem_wr,
  output logic [7:0]         dmem_addr,
  input  logic               dmem_ready,
  output logic [1:0]         alu_op,
  output logic               alu_sel,
  output logic               reg_we,
  input  logic               zero_flag,
  output logic [PC_W-1:0]    pc,
  output logic [7:0]         opcode,
  output logic               halted,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired
);

  state_t             state, next_state;
  logic [INSTR_W-1:0] ir, ir_next;
  logic [PC_W-1:0]    pc_next;
  logic [CNT_W-1:0]   retired_next;
  logic               halted_next, illegal_next;
  logic               imem_req_next, dmem_rd_next, dmem_wr_next, reg_we_next;
  logic [1:0]         alu_op_next;

  logic       is_alu, is_load, is_store, is_branch, is_halt, is_illegal;
  logic [1:0] dec_alu_op;
  logic       fetch_done, mem_done;

  assign opcode    = ir[INSTR_W-1 -: 8];
  assign alu_sel   = ir[8];
  assign dmem_addr = ir[7:0];
  assign imem_addr = pc;

  cpu_decode u_decode (
    .opcode     (opcode),
    .is_alu     (is_alu),
    .is_load    (is_load),
    .is_store   (is_store),
    .is_branch  (is_branch),
    .is_halt    (is_halt),
    .is_illegal (is_illegal),
    .alu_op     (dec_alu_op)
  );

  // Handshakes only count while the matching strobe is actually on the bus.
  assign fetch_done = imem_req && imem_ready;
  assign mem_done   = (dmem_rd || dmem_wr) && dmem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    ir_next      = ir;
    pc_next      = pc;
    retired_next = retired;
    halted_next  = halted;
    illegal_next = illegal;

    case (state)
      FETCH: begin
        if (halted) begin
          next_state = HALT;
        end else if (fetch_done) begin
          ir_next    = imem_rdata;
          pc_next    = pc + PC_W'(1);
          next_state = DECODE;
        end
      end
      DECODE: begin
        if (is_halt) begin
          halted_next  = 1'b1;
          retired_next = retired + CNT_W'(1);
          next_state   = HALT;
        end else if (is_illegal) begin
          halted_next  = 1'b1;
          illegal_next = 1'b1;
          next_state   = HALT;
        end else if (is_load || is_store) begin
          next_state = MEM;
        end else if (is_alu || is_branch) begin
          next_state = EXEC;
        end
      end
      EXEC: begin
        if (is_branch) begin
          if (zero_flag) begin
            pc_next = ir[PC_W-1:0];
          end
          retired_next = retired + CNT_W'(1);
          next_state   = FETCH;
        end else begin
          next_state = WB;
        end
      end
      MEM: begin
        if (mem_done) begin
          if (is_load) begin
            next_state = WB;
          end else begin
            retired_next = retired + CNT_W'(1);
            next_state   = FETCH;
          end
        end
      end
      WB: begin
        retired_next = retired + CNT_W'(1);
        next_state   = FETCH;
      end
      HALT: begin
        next_state = HALT;
      end
      default: begin
        next_state = HALT;
      end
    endcase

    // Strobes for the coming cycle, derived from the state being entered.
    imem_req_next = (next_state == FETCH) && !halted_next;
    dmem_rd_next  = (next_state == MEM) && is_load;
    dmem_wr_next  = (next_state == MEM) && is_store;
    reg_we_next   = (next_state == WB);
    alu_op_next   = (next_state == EXEC) ? dec_alu_op : ALU_NONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir       <= '0;
      pc       <= '0;
      retired  <= '0;
      halted   <= 1'b0;
      illegal  <= 1'b0;
      imem_req <= 1'b0;
      dmem_rd  <= 1'b0;
      dmem_wr  <= 1'b0;
      reg_we   <= 1'b0;
      alu_op   <= ALU_NONE;
    end else begin
      ir       <= ir_next;
      pc       <= pc_next;
      retired  <= retired_next;
      halted   <= halted_next;
      illegal  <= illegal_next;
      imem_req <= imem_req_next;
      dmem_rd  <= dmem_rd_next;
      dmem_wr  <= dmem_wr_next;
      reg_we   <= reg_we_next;
      alu_op   <= alu_op_next;
    end
  end

endmodule
